// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared widths, FSM encoding and Q1.7 constants for the MAC operand sequencer
package mac_seq_pkg;
  localparam int OP_DW = 8;
  localparam int TAPS_DEF = 4;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;
  localparam logic [OP_DW-1:0] Q_HALF = 8'h40;
  localparam logic [OP_DW-1:0] Q_NEG_HALF = 8'hC0;
endpackage

// File: rtl/mac_coef_bank.sv
// mac_coef_bank: double-buffered coefficients; shadow takes writes, active loads on frame start
module mac_coef_bank
  import mac_seq_pkg::*;
#(
  parameter int TAPS = TAPS_DEF,
  parameter int DW = OP_DW,
  parameter int AW = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          load,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  output logic [DW-1:0] head
);
  logic [DW-1:0] shadow [TAPS];
  logic [DW-1:0] active [TAPS];
  logic wr_ok;
  assign wr_ok = we && (int'(waddr) < TAPS);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < TAPS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    else
      for (int i = 0; i < TAPS; i++) begin
        if (wr_ok && int'(waddr) == i) shadow[i] <= wdata;
        // a write landing on the load edge goes straight into the new active bank
        if (load) active[i] <= (wr_ok && int'(waddr) == i) ? wdata : shadow[i];
      end
  assign rdata = active[raddr];
  assign head = (wr_ok && waddr == '0) ? wdata : shadow[0];
endmodule

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: sample delay line plus FSM streaming (x[i], coef[i]) pairs to the MAC
module mac_operand_sequencer
  import mac_seq_pkg::*;
#(
  parameter int TAPS = TAPS_DEF,
  parameter int DW = OP_DW,
  parameter int AW = $clog2(TAPS)
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic [DW-1:0] S_DATA,
  input  logic          S_VALID,
  output logic          S_READY,
  input  logic          C_WE,
  input  logic [AW-1:0] C_ADDR,
  input  logic [DW-1:0] C_DATA,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic          OP_VALID,
  output logic          ACC_CLR,
  output logic          OP_LAST,
  output logic [7:0]    FRAME_CNT
);
  logic [DW-1:0] x [TAPS];
  logic [0:0] state;
  logic [AW-1:0] idx, idx_nx;
  logic [DW-1:0] coef_rd, coef_head;
  logic accept, last;
  assign accept = S_VALID && S_READY;
  assign idx_nx = idx + 1'b1;
  assign last = int'(idx) == TAPS - 1;
  mac_coef_bank #(.TAPS(TAPS), .DW(DW), .AW(AW)) u_bank (
    .clk(CLK),
    .rst_n(RESET_N),
    .we(C_WE),
    .waddr(C_ADDR),
    .wdata(C_DATA),
    .load(accept),
    .raddr(idx_nx),
    .rdata(coef_rd),
    .head(coef_head)
  );
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      for (int i = 0; i < TAPS; i++) x[i] <= '0;
      state <= IDLE;
      idx <= '0;
      A <= '0;
      B <= '0;
      OP_VALID <= 1'b0;
      ACC_CLR <= 1'b0;
      OP_LAST <= 1'b0;
      S_READY <= 1'b0;
      FRAME_CNT <= '0;
    end else if (accept) begin
      x[0] <= S_DATA;
      for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
      FRAME_CNT <= FRAME_CNT + 8'd1;
      A <= S_DATA;
      B <= coef_head;
      OP_VALID <= 1'b1;
      ACC_CLR <= 1'b1;
      OP_LAST <= 1'b0;
      S_READY <= 1'b0;
      idx <= '0;
      state <= ISSUE;
    end else if (state == ISSUE && !last) begin
      // x is already shifted, so x[idx_nx] is the sample idx_nx steps back
      idx <= idx_nx;
      A <= x[idx_nx];
      B <= coef_rd;
      ACC_CLR <= 1'b0;
      OP_LAST <= int'(idx_nx) == TAPS - 1;
      S_READY <= int'(idx_nx) == TAPS - 1;
    end else begin
      state <= IDLE;
      OP_VALID <= 1'b0;
      ACC_CLR <= 1'b0;
      OP_LAST <= 1'b0;
      S_READY <= 1'b1;
    end
endmodule
